vote_collector: RTL and testbench
=================================

Name: vote_collector

Overview:
Ballot-collection front end for the 3-voter majority circuit on the STEP MXO2 board. It debounces three yes/no key pairs and opens a timed voting window on a chairman start key. It latches one vote per voter, then closes the ballot and presents the votes as a, b, c with a one-cycle ballot_valid strobe. It also registers the majority result for the board LEDs.

Parameters:
DEB_CYCLES, 240000, clock cycles a key level must stay stable to count as a press (20 ms at 12 MHz)
SEC_CYCLES, 12000000, clock cycles per one-second window tick
WINDOW_S, 10, voting window length in seconds, 1..15

Ports:
clk  input  1  system clock, 12 MHz on board
rst  input  1  synchronous reset, active-high
start_n  input  1  chairman key, active-low, asynchronous to clk
key_yes_n  input  3  voter i "yes" key in bit i, active-low, asynchronous
key_no_n  input  3  voter i "no" key in bit i, active-low, asynchronous
a  output  1  voter 0 ballot, held until the next close
b  output  1  voter 1 ballot, held until the next close
c  output  1  voter 2 ballot, held until the next close
ballot_valid  output  1  one-cycle strobe when a/b/c update
pass  output  1  registered majority of a, b, c
busy  output  1  high while the window is open
cast  output  3  bit i high once voter i has voted in the current window
secs_left  output  4  seconds remaining in the window, 0 when idle

Behaviour:
- Reset: a=b=c=0, ballot_valid=0, pass=0, busy=0, cast=0, secs_left=0; FSM goes to IDLE; prescaler, debouncers and vote registers are cleared.
- Reset mid-window aborts the ballot. No ballot_valid is issued.
- Key path, applied to each of the 7 keys:
  - 2-flop synchronizer, then debounce counter.
  - A press pulse (1 cycle) fires when the synchronized level has been low for exactly DEB_CYCLES consecutive cycles.
  - One pulse per press. Release needs no pulse. A glitch shorter than DEB_CYCLES restarts the count and produces no pulse.
- FSM states: IDLE, OPEN, CLOSE.
- IDLE:
  - Outputs a/b/c/pass hold their last values.
  - A start press moves to OPEN. On that transition: cast=0, vote regs=0, secs_left=WINDOW_S, prescaler=0, busy=1.
- OPEN:
  - Yes press for voter i with cast[i]=0: vote[i]=1, cast[i]=1 on the next edge.
  - No press for voter i with cast[i]=0: vote[i]=0, cast[i]=1.
  - Yes and no pulses from the same voter in the same cycle are both ignored; cast is unchanged.
  - Any press from a voter with cast[i]=1 is ignored. Votes are final.
  - Presses from different voters in the same cycle are all accepted.
  - start presses are ignored.
  - Prescaler counts 0..SEC_CYCLES-1. On wrap, secs_left decrements.
  - Leave for CLOSE on the cycle cast becomes 3'b111, or when secs_left would decrement from 1 to 0.
  - If both close conditions occur in the same cycle, one CLOSE results and votes cast that cycle count.
- CLOSE (exactly 1 cycle):
  - a=vote[0], b=vote[1], c=vote[2]; an uncast voter counts as 0.
  - pass = (v0&v1)|(v1&v2)|(v0&v2), computed from the same vote values.
  - ballot_valid=1, busy=0, secs_left=0.
  - Next state IDLE. ballot_valid is 0 in all other states.
- Latency:
  - Key press to cast[i] update: DEB_CYCLES+3 cycles after the key pin goes low.
  - Last vote to ballot_valid: 1 cycle after cast is full.
- Keys pressed in IDLE are ignored. Keys held across the start transition do not re-fire.

Decomposition:
- Shared package: FSM state encoding (IDLE, OPEN, CLOSE) and the default timing constants (12 MHz clock, 20 ms debounce).
- Sub-module key_debounce, instantiated 7 times: synchronizer, debounce counter and press-pulse output, parameterised by DEB_CYCLES.
- vote_collector holds the FSM, prescaler, vote/cast registers and output registers.

Test Plan:
All scenarios use DEB_CYCLES=4, SEC_CYCLES=10, WINDOW_S=3.
1. Reset and start: start_n low 6 cycles -> busy=1, secs_left=3, cast=000. secs_left steps 3→2→1 every 10 cycles.
2. Full ballot: yes0, no1, yes2 pressed in sequence -> cast 001→011→111. One cycle later, ballot_valid=1 for 1 cycle with a=1, b=0, c=1, pass=1. Then busy=0.
3. Timeout: start, only yes1 pressed -> after 30 cycles, ballot_valid with a=0, b=1, c=0, pass=0.
4. Rules: voter 0 presses no, then yes -> a=0. Voter 2 yes and no simultaneously -> cast[2] stays 0. A 2-cycle glitch on key_yes_n[1] -> no vote.
5. Simultaneous close: last vote accepted in the same cycle as the final tick -> exactly one ballot_valid, and the last vote is counted.
6. Reset mid-window: after 2 votes, rst high 1 cycle -> all outputs 0, no ballot_valid. A start press afterwards opens a fresh window.

Source files
------------

// File: rtl/vote_collector_pkg.sv
// Shared types and default timing for the ballot-collection front end.
// Defaults assume the 12 MHz board clock and a 20 ms debounce.
package vote_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_CLOSE = 2'd2
    } state_t;

    localparam int CLK_HZ         = 12_000_000;
    localparam int DEB_CYCLES_DEF = CLK_HZ / 50;
    localparam int SEC_CYCLES_DEF = CLK_HZ;
    localparam int WINDOW_S_DEF   = 10;

    function automatic logic majority3(input logic [2:0] v);
        return (v[0] & v[1]) | (v[1] & v[2]) | (v[0] & v[2]);
    endfunction

endpackage

// File: rtl/vote_collector_key_debounce.sv
// Active-low key synchronizer + debouncer; one-cycle press pulse DEB_CYCLES+2 cycles after the pin falls.
// No backpressure: the pulse is fire-and-forget, release produces nothing.
module key_debounce
    import vote_collector_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_press
);

    localparam int             CW     = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0]  C_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0]  C_SAT  = CW'(DEB_CYCLES);

    logic          r_sync0;
    logic          r_sync1;
    logic [CW-1:0] r_cnt;
    logic          r_press;

    // Counter saturates at DEB_CYCLES so a held key fires exactly once.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync0 <= 1'b1;
            r_sync1 <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync0 <= i_key_n;
            r_sync1 <= r_sync0;
            r_press <= 1'b0;
            if (r_sync1) begin
                r_cnt <= '0;
            end else if (r_cnt != C_SAT) begin
                r_cnt   <= r_cnt + 1'b1;
                r_press <= (r_cnt == C_LAST);
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/vote_collector.sv
// Three-voter ballot collector: timed window, one final vote per voter, one-cycle ballot_valid with registered majority.
// Ballot appears 1 cycle after the last vote or the final tick; no backpressure, ballot_valid is a strobe.
module vote_collector
    import vote_collector_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int SEC_CYCLES = SEC_CYCLES_DEF,
    parameter int WINDOW_S   = WINDOW_S_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_n,
    input  logic [2:0] key_yes_n,
    input  logic [2:0] key_no_n,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       ballot_valid,
    output logic       pass,
    output logic       busy,
    output logic [2:0] cast,
    output logic [3:0] secs_left
);

    localparam int            PW       = $clog2(SEC_CYCLES + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(SEC_CYCLES - 1);
    localparam logic [3:0]    WIN_INIT = 4'(WINDOW_S);

    logic [2:0]    w_yes_p;
    logic [2:0]    w_no_p;
    logic          w_start_p;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [2:0]    r_vote;
    logic [2:0]    r_cast;
    logic [2:0]    w_vote_nxt;
    logic [2:0]    w_cast_nxt;
    logic [PW-1:0] r_pre;
    logic [3:0]    r_secs;
    logic          w_tick;
    logic          w_timeout;
    logic          w_full;
    logic          w_open_entry;
    logic          w_in_open;
    logic          w_in_close;

    genvar gi;
    for (gi = 0; gi < 3; gi++) begin : g_voter
        key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_yes (
            .clk     (clk),
            .rst     (rst),
            .i_key_n (key_yes_n[gi]),
            .o_press (w_yes_p[gi])
        );
        key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_no (
            .clk     (clk),
            .rst     (rst),
            .i_key_n (key_no_n[gi]),
            .o_press (w_no_p[gi])
        );
    end

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_start (
        .clk     (clk),
        .rst     (rst),
        .i_key_n (start_n),
        .o_press (w_start_p)
    );

    // A voter's first unambiguous press is final; yes+no together counts as neither.
    always_comb begin
        w_vote_nxt = r_vote;
        w_cast_nxt = r_cast;
        for (int i = 0; i < 3; i++) begin
            if (!r_cast[i] && (w_yes_p[i] ^ w_no_p[i])) begin
                w_vote_nxt[i] = w_yes_p[i];
                w_cast_nxt[i] = 1'b1;
            end
        end
    end

    assign w_tick    = (r_pre == PRE_LAST);
    assign w_timeout = w_tick && (r_secs == 4'd1);
    assign w_full    = (w_cast_nxt == 3'b111);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_p) w_state_nxt = ST_OPEN;
            ST_OPEN:  if (w_full || w_timeout) w_state_nxt = ST_CLOSE;
            ST_CLOSE: w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_open_entry = 1'b0;
        w_in_open    = 1'b0;
        w_in_close   = 1'b0;
        case (r_state)
            ST_IDLE:  w_open_entry = w_start_p;
            ST_OPEN:  w_in_open    = 1'b1;
            ST_CLOSE: w_in_close   = 1'b1;
            default:  ;
        endcase
    end

    // Votes accepted on the final tick still land in r_vote before CLOSE samples it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vote       <= '0;
            r_cast       <= '0;
            r_pre        <= '0;
            r_secs       <= '0;
            a            <= 1'b0;
            b            <= 1'b0;
            c            <= 1'b0;
            pass         <= 1'b0;
            ballot_valid <= 1'b0;
            busy         <= 1'b0;
        end else begin
            ballot_valid <= 1'b0;
            if (w_open_entry) begin
                r_vote <= '0;
                r_cast <= '0;
                r_pre  <= '0;
                r_secs <= WIN_INIT;
                busy   <= 1'b1;
            end
            if (w_in_open) begin
                r_vote <= w_vote_nxt;
                r_cast <= w_cast_nxt;
                if (w_tick) begin
                    r_pre <= '0;
                    if (!w_timeout) r_secs <= r_secs - 4'd1;
                end else begin
                    r_pre <= r_pre + 1'b1;
                end
            end
            if (w_in_close) begin
                a            <= r_vote[0];
                b            <= r_vote[1];
                c            <= r_vote[2];
                pass         <= majority3(r_vote);
                ballot_valid <= 1'b1;
                busy         <= 1'b0;
                r_secs       <= '0;
            end
        end
    end

    assign cast      = r_cast;
    assign secs_left = r_secs;

endmodule

// File: tb/tb_vote_collector.sv
// Bench for vote_collector: directed ballot scenarios, then random key activity against a cycle reference model.
module tb_vote_collector;

    localparam int DEB = 4;
    localparam int SEC = 10;
    localparam int WIN = 3;

    localparam logic [6:0] YES0  = 7'b000_0001;
    localparam logic [6:0] YES1  = 7'b000_0010;
    localparam logic [6:0] YES2  = 7'b000_0100;
    localparam logic [6:0] NO0   = 7'b000_1000;
    localparam logic [6:0] NO1   = 7'b001_0000;
    localparam logic [6:0] NO2   = 7'b010_0000;
    localparam logic [6:0] START = 7'b100_0000;

    logic       clk  = 1'b0;
    logic       rst  = 1'b1;
    logic [6:0] pins = '1;
    logic       start_n;
    logic [2:0] key_yes_n, key_no_n;
    logic       a, b, c, ballot_valid, pass, busy;
    logic [2:0] cast;
    logic [3:0] secs_left;

    int n_checks = 0;
    int n_errors = 0;
    int n_valid  = 0;
    int cyc      = 0;

    // reference model state
    logic [15:0] m_hist [7];
    logic        m_open, m_close;
    logic [2:0]  m_vote, m_cast;
    int          m_secs, m_pre;
    logic        m_a, m_b, m_c, m_valid, m_pass, m_busy;
    logic [2:0]  last_abc;
    logic        last_pass;

    assign start_n   = pins[6];
    assign key_no_n  = pins[5:3];
    assign key_yes_n = pins[2:0];

    always #5 clk = ~clk;

    vote_collector #(
        .DEB_CYCLES (DEB),
        .SEC_CYCLES (SEC),
        .WINDOW_S   (WIN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_n      (start_n),
        .key_yes_n    (key_yes_n),
        .key_no_n     (key_no_n),
        .a            (a),
        .b            (b),
        .c            (c),
        .ballot_valid (ballot_valid),
        .pass         (pass),
        .busy         (busy),
        .cast         (cast),
        .secs_left    (secs_left)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: advance the model from the pin levels seen at this edge, then compare.
    task automatic step();
        logic [6:0] pv;
        logic [6:0] pe;
        logic       timeout;
        pv      = pins;
        pe      = '0;
        timeout = 1'b0;
        @(posedge clk);
        cyc++;
        if (rst) begin
            for (int k = 0; k < 7; k++) m_hist[k] = '1;
            m_open = 0; m_close = 0; m_vote = 0; m_cast = 0; m_secs = 0; m_pre = 0;
            m_a = 0; m_b = 0; m_c = 0; m_valid = 0; m_pass = 0; m_busy = 0;
        end else begin
            // a press is seen once the pin has been low for exactly DEB samples, 2 sync stages late
            for (int k = 0; k < 7; k++) begin
                m_hist[k] = {m_hist[k][14:0], pv[k]};
                pe[k] = (m_hist[k][DEB+2:3] == '0) && m_hist[k][DEB+3];
            end
            m_valid = 0;
            if (m_close) begin
                {m_c, m_b, m_a} = m_vote;
                m_pass  = ($countones(m_vote) >= 2);
                m_valid = 1;
                m_busy  = 0;
                m_secs  = 0;
                m_close = 0;
            end else if (m_open) begin
                for (int i = 0; i < 3; i++) begin
                    if (!m_cast[i] && (pe[i] != pe[3+i])) begin
                        m_cast[i] = 1'b1;
                        m_vote[i] = pe[i];
                    end
                end
                if (m_pre == SEC - 1) begin
                    m_pre = 0;
                    if (m_secs == 1) timeout = 1'b1;
                    else m_secs--;
                end else begin
                    m_pre++;
                end
                if (m_cast == 3'b111 || timeout) begin
                    m_open  = 0;
                    m_close = 1;
                end
            end else if (pe[6]) begin
                m_open = 1; m_cast = 0; m_vote = 0; m_secs = WIN; m_pre = 0; m_busy = 1;
            end
        end
        #1;
        check("abc",   {a, b, c}, {m_a, m_b, m_c});
        check("valid", ballot_valid, m_valid);
        check("pass",  pass, m_pass);
        check("busy",  busy, m_busy);
        check("cast",  cast, m_cast);
        check("secs",  secs_left, m_secs);
        if (ballot_valid === 1'b1) begin
            n_valid++;
            last_abc  = {a, b, c};
            last_pass = pass;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic press(input logic [6:0] mask, input int n);
        pins = pins & ~mask;
        idle(n);
        pins = pins | mask;
    endtask

    task automatic open_window();
        press(START, 6);
        step();
        check("open_busy", busy, 1);
        check("open_secs", secs_left, WIN);
        check("open_cast", cast, 0);
    endtask

    task automatic wait_ballot(input string tag, input int budget);
        int v0 = n_valid;
        int i  = 0;
        while (n_valid == v0 && i < budget) begin
            step();
            i++;
        end
        check(tag, n_valid != v0, 1);
    endtask

    initial begin
        int v0;

        // reset and timed window with no votes
        rst = 1'b1;
        idle(2);
        check("rst_out", {a, b, c, ballot_valid, pass, busy, cast, secs_left}, 0);
        rst = 1'b0;
        idle(3);
        open_window();
        idle(10);
        check("s1_secs2", secs_left, 2);
        idle(10);
        check("s1_secs1", secs_left, 1);
        wait_ballot("s1_ballot", 15);
        check("s1_abc", last_abc, 3'b000);

        // full ballot
        idle(3);
        open_window();
        press(YES0, 6); step();
        check("s2_cast1", cast, 3'b001);
        press(NO1, 6); step();
        check("s2_cast2", cast, 3'b011);
        press(YES2, 6); step();
        check("s2_cast3", cast, 3'b111);
        step();
        check("s2_valid", ballot_valid, 1);
        check("s2_abc", {a, b, c}, 3'b101);
        check("s2_pass", pass, 1);
        step();
        check("s2_valid_off", ballot_valid, 0);
        check("s2_busy_off", busy, 0);

        // timeout with a single vote
        idle(3);
        open_window();
        press(YES1, 6);
        wait_ballot("s3_ballot", 40);
        check("s3_abc", last_abc, 3'b010);
        check("s3_pass", last_pass, 0);

        // rules: final votes, conflicting pair, glitch
        idle(3);
        open_window();
        press(NO0, 6); step();
        press(YES0, 6); step();
        press(YES2 | NO2, 6); step();
        check("s4_cast", cast, 3'b001);
        press(YES1, 2);
        wait_ballot("s4_ballot", 40);
        check("s4_abc", last_abc, 3'b000);
        check("s4_cast_end", cast, 3'b001);

        // last vote on the final tick
        idle(3);
        open_window();
        press(YES0, 6); step();
        press(NO1, 6); step();
        idle(9);
        press(YES2, 6);
        v0 = n_valid;
        step();
        check("s5_cast", cast, 3'b111);
        check("s5_secs", secs_left, 1);
        step();
        check("s5_valid", ballot_valid, 1);
        check("s5_abc", {a, b, c}, 3'b101);
        check("s5_pass", pass, 1);
        idle(10);
        check("s5_count", n_valid - v0, 1);

        // reset mid-window
        idle(3);
        open_window();
        press(YES0, 6); step();
        press(YES1, 6); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("s6_rst_out", {a, b, c, ballot_valid, pass, busy, cast, secs_left}, 0);
        v0 = n_valid;
        idle(35);
        check("s6_no_ballot", n_valid - v0, 0);
        open_window();
        wait_ballot("s6_ballot", 40);

        // random key activity
        for (int n = 0; n < 3000; n++) begin
            for (int k = 0; k < 7; k++) begin
                if ($urandom_range(0, 9) == 0) pins[k] = ~pins[k];
            end
            rst = ($urandom_range(0, 399) == 0);
            step();
        end
        rst  = 1'b0;
        pins = '1;
        idle(40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
